// File: rtl/comparador_parejas.sv
// comparador_parejas: pair-comparison stage of the memory game.
// Takes two card selections per turn and compares their face values.
// Matched cards stay face up. A mismatched pair is shown for SHOW_CYCLES
// cycles, then hidden, and the turn passes to the other player.
// Optional feature macro: TURN_TIMEOUT_EN. When it is defined, an idle
// turn is forced to end after TIMEOUT cycles without an accepted selection.
module comparador_parejas #(
    parameter int NCARDS      = 18,
    parameter int VAL_W       = 4,
    parameter int SHOW_CYCLES = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCARDS*VAL_W-1:0] tablero,
    input  logic                    sel_valid,
    input  logic [4:0]              sel_idx,
    output logic                    pareja,
    output logic                    error_sel,
    output logic [NCARDS-1:0]       visible,
    output logic                    turno,
    output logic                    ocupado
);
    localparam int CNT_W = $clog2(SHOW_CYCLES + 1);
    localparam logic [5:0] NCARDS_6 = 6'(NCARDS);

    // Parameter sanity checks, evaluated at elaboration.
    if ((NCARDS % 2) != 0 || NCARDS > 32 || NCARDS < 2) begin : g_bad_ncards
        $error("comparador_parejas: NCARDS must be even and in 2..32");
    end
    if (SHOW_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_times
        $error("comparador_parejas: SHOW_CYCLES and TIMEOUT must be >= 1");
    end

    typedef enum logic [2:0] {IDLE, UNA, CHECK, MATCH, SHOW} state_t;

    state_t            state_reg, state_next;
    logic [4:0]        primera_reg, primera_next;
    logic [4:0]        segunda_reg, segunda_next;
    logic [NCARDS-1:0] emp_reg, emp_next;
    logic              turno_reg, turno_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              error_reg, error_next;

    // Card values unpacked into a 32-entry table so any 5-bit index is legal.
    logic [VAL_W-1:0] vals [32];
    logic [31:0]      emp_ext;
    logic [31:0]      prim_oh;
    logic [31:0]      seg_oh;
    logic             sel_ok;

    for (genvar gi = 0; gi < 32; gi++) begin : g_vals
        if (gi < NCARDS) begin : g_card
            assign vals[gi] = tablero[gi*VAL_W +: VAL_W];
        end else begin : g_pad
            assign vals[gi] = '0;
        end
    end

    assign emp_ext = 32'(emp_reg);
    assign prim_oh = 32'd1 << primera_reg;
    assign seg_oh  = 32'd1 << segunda_reg;

    // A selection is acceptable if it is on the board, unmatched and, when
    // choosing the second card, different from the first.
    assign sel_ok = sel_valid
                 && ({1'b0, sel_idx} < NCARDS_6)
                 && !emp_ext[sel_idx]
                 && !(state_reg == UNA && sel_idx == primera_reg);

`ifdef TURN_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_reg, idle_next;
`endif

    // Next-state and datapath update for the turn sequencer.
    always_comb begin
        state_next   = state_reg;
        primera_next = primera_reg;
        segunda_next = segunda_reg;
        emp_next     = emp_reg;
        turno_next   = turno_reg;
        cnt_next     = cnt_reg;
        error_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sel_valid) begin
                    if (sel_ok) begin
                        state_next   = UNA;
                        primera_next = sel_idx;
                    end else begin
                        error_next = 1'b1;
                    end
                end
            end
            UNA: begin
                if (sel_valid) begin
                    if (sel_ok) begin
                        state_next   = CHECK;
                        segunda_next = sel_idx;
                    end else begin
                        error_next = 1'b1;
                    end
                end
            end
            CHECK: begin
                if (vals[primera_reg] == vals[segunda_reg]) begin
                    state_next = MATCH;
                    emp_next   = emp_reg | prim_oh[NCARDS-1:0] | seg_oh[NCARDS-1:0];
                end else begin
                    state_next = SHOW;
                    cnt_next   = CNT_W'(SHOW_CYCLES - 1);
                end
            end
            MATCH: begin
                state_next = IDLE;
            end
            SHOW: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                    turno_next = ~turno_reg;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
`ifdef TURN_TIMEOUT_EN
        // Idle watchdog: an accepted selection wins over a same-edge timeout.
        idle_next = '0;
        if (state_reg == IDLE || state_reg == UNA) begin
            if (sel_ok) begin
                idle_next = '0;
            end else if (idle_reg == IDLE_W'(TIMEOUT - 1)) begin
                idle_next  = '0;
                state_next = IDLE;
                turno_next = ~turno_reg;
            end else begin
                idle_next = idle_reg + 1'b1;
            end
        end
`endif
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            primera_reg <= '0;
            segunda_reg <= '0;
            emp_reg     <= '0;
            turno_reg   <= 1'b0;
            cnt_reg     <= '0;
            error_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            primera_reg <= primera_next;
            segunda_reg <= segunda_next;
            emp_reg     <= emp_next;
            turno_reg   <= turno_next;
            cnt_reg     <= cnt_next;
            error_reg   <= error_next;
        end
    end

`ifdef TURN_TIMEOUT_EN
    // Idle watchdog counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_reg <= '0;
        end else begin
            idle_reg <= idle_next;
        end
    end
`endif

    // Outputs decoded from registered state only.
    always_comb begin
        visible = emp_reg;
        if (state_reg == UNA || state_reg == CHECK || state_reg == SHOW) begin
            visible = visible | prim_oh[NCARDS-1:0];
        end
        if (state_reg == CHECK || state_reg == SHOW) begin
            visible = visible | seg_oh[NCARDS-1:0];
        end
    end

    assign pareja    = (state_reg == MATCH);
    assign error_sel = error_reg;
    assign turno     = turno_reg;
    assign ocupado   = (state_reg == CHECK) || (state_reg == MATCH) || (state_reg == SHOW);

endmodule
